// File: rtl/trace_pkg.sv
// trace_pkg: shared capture-state type, default widths and depth helper for the trace controller
package trace_pkg;
    localparam int DEF_TRIG_W  = 1;
    localparam int DEF_TRACE_W = 6;
    localparam int DEF_ADDR_W  = 8;

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} cap_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/trace_trig_match.sv
// trace_trig_match: masked trigger compare
//   en    : global qualifier, no match while low
//   din   : live trigger signals
//   mask  : 1 = bit takes part in the compare
//   value : required value of the participating bits
//   match : combinational match result
module trace_trig_match #(
    parameter int TRIG_W = 1
) (
    input  logic              en,
    input  logic [TRIG_W-1:0] din,
    input  logic [TRIG_W-1:0] mask,
    input  logic [TRIG_W-1:0] value,
    output logic              match
);
    assign match = en && !(|((din ^ value) & mask));
endmodule

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: logic-analyzer trace buffer sequencer (arm, circular capture, trigger, post-count, freeze)
//   clk, reset_n          : capture clock, asynchronous active-low reset
//   arm, abort            : start a capture / cancel back to idle
//   trigger_en, trigger_din, trig_mask, trig_value : masked trigger compare inputs
//   post_cnt              : post-trigger sample count, taken at arm
//   trace_din             : trace sample
//   wr_en, wr_addr, wr_data : registered trace RAM write port
//   busy, triggered, done : capture status
//   trig_addr, oldest_addr, num_samples : buffer layout for the unload side
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int TRIG_W  = DEF_TRIG_W,
    parameter int TRACE_W = DEF_TRACE_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger_en,
    input  logic [TRIG_W-1:0]  trigger_din,
    input  logic [TRIG_W-1:0]  trig_mask,
    input  logic [TRIG_W-1:0]  trig_value,
    input  logic [ADDR_W-1:0]  post_cnt,
    input  logic [TRACE_W-1:0] trace_din,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [TRACE_W-1:0] wr_data,
    output logic               busy,
    output logic               triggered,
    output logic               done,
    output logic [ADDR_W-1:0]  trig_addr,
    output logic [ADDR_W-1:0]  oldest_addr,
    output logic [ADDR_W:0]    num_samples
);
    localparam int DEPTH = depth_of(ADDR_W);

    cap_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_len;
    logic [ADDR_W-1:0] rem;
    logic              wrapped;
    logic              match;
    logic              capturing;

    trace_trig_match #(.TRIG_W(TRIG_W)) u_match (
        .en   (trigger_en),
        .din  (trigger_din),
        .mask (trig_mask),
        .value(trig_value),
        .match(match)
    );

    assign capturing   = (state == ARMED) || (state == POST);
    assign oldest_addr = wrapped ? wr_ptr : '0;
    assign num_samples = wrapped ? (ADDR_W+1)'(DEPTH) : {1'b0, wr_ptr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            post_len  <= '0;
            rem       <= '0;
            wrapped   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            trig_addr <= '0;
        end else begin
            wr_en <= capturing && !abort;
            // done trails the state by one cycle so it rises after the final write is on the port
            done  <= (state == DONE) && !abort && !arm;
            if (capturing && !abort) begin
                wr_addr <= wr_ptr;
                wr_data <= trace_din;
                wr_ptr  <= wr_ptr + 1'b1;
                if (&wr_ptr) wrapped <= 1'b1;
            end
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                triggered <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: if (arm) begin
                        state     <= ARMED;
                        busy      <= 1'b1;
                        wr_ptr    <= '0;
                        wrapped   <= 1'b0;
                        triggered <= 1'b0;
                        // an ADDR_W-bit count can never exceed DEPTH-1, so no clamp logic is needed
                        post_len  <= post_cnt;
                    end
                    ARMED: if (match) begin
                        trig_addr <= wr_ptr;
                        triggered <= 1'b1;
                        rem       <= post_len;
                        state     <= (post_len == '0) ? DONE : POST;
                        busy      <= post_len != '0;
                    end
                    POST: begin
                        rem <= rem - 1'b1;
                        if (rem == ADDR_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: self-checking bench for trace_capture_ctrl (vector table, directed sequences, randomized captures vs. a transaction model)
module tb_trace_capture_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       arm;
    logic       abort;
    logic       trigger_en;
    logic [0:0] trigger_din;
    logic [0:0] trig_mask;
    logic [0:0] trig_value;
    logic [7:0] post_cnt;
    logic [5:0] trace_din;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [5:0] wr_data;
    logic       busy;
    logic       triggered;
    logic       done;
    logic [7:0] trig_addr;
    logic [7:0] oldest_addr;
    logic [8:0] num_samples;

    int checks = 0;
    int failures = 0;
    logic [7:0] got_a[$];
    logic [5:0] got_d[$];

    typedef struct {
        logic en;
        logic din;
        logic mask;
        logic value;
        logic exp;
    } vec_t;
    vec_t tbl[8];

    trace_capture_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arm        (arm),
        .abort      (abort),
        .trigger_en (trigger_en),
        .trigger_din(trigger_din),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .post_cnt   (post_cnt),
        .trace_din  (trace_din),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_addr  (trig_addr),
        .oldest_addr(oldest_addr),
        .num_samples(num_samples)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en) begin
            got_a.push_back(wr_addr);
            got_d.push_back(wr_data);
        end
    endtask

    // One capture: the model predicts the write stream from the samples and trigger inputs it drives.
    // quiet: leading cycles with trigger_en low but din matching; rnd: random trigger inputs afterwards.
    task automatic run(input int post, input int quiet, input bit rnd);
        logic [5:0] exp_d[$];
        int t;
        int k;
        int n;
        int bad;
        got_a.delete();
        got_d.delete();
        post_cnt   = 8'(post);
        trigger_en = 1'b1;
        trig_mask  = 1'b0;
        trace_din  = 6'($urandom);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        post_cnt = 8'($urandom);
        t = -1;
        k = 0;
        while (t < 0 || k <= t + post) begin
            if (quiet > 0 && k == quiet) begin
                chk("quiet_triggered", int'(triggered), 0);
                chk("quiet_busy", int'(busy), 1);
            end
            trace_din = 6'($urandom);
            if (k < quiet) begin
                trigger_en  = 1'b0;
                trig_mask   = 1'b1;
                trig_value  = 1'($urandom);
                trigger_din = trig_value;
            end else if (!rnd || k >= quiet + 400) begin
                trigger_en = 1'b1;
                trig_mask  = 1'b0;
            end else begin
                trigger_en  = 1'($urandom);
                trig_mask   = 1'($urandom);
                trig_value  = 1'($urandom);
                trigger_din = 1'($urandom);
            end
            if (t < 0 && trigger_en && ((trigger_din ^ trig_value) & trig_mask) == 1'b0) t = k;
            exp_d.push_back(trace_din);
            tick();
            k++;
        end
        trigger_en = 1'b0;
        chk("done_early", int'(done), 0);
        tick();
        chk("done_rise", int'(done), 1);
        repeat (3) begin
            trace_din = 6'($urandom);
            tick();
        end
        n = exp_d.size();
        chk("wr_count", got_a.size(), n);
        bad = 0;
        for (int j = 0; j < n && j < got_a.size(); j++)
            if (got_a[j] != 8'(j % 256) || got_d[j] != exp_d[j]) bad++;
        chk("wr_seq_bad", bad, 0);
        chk("trig_addr", int'(trig_addr), t % 256);
        chk("triggered", int'(triggered), 1);
        chk("busy_done", int'(busy), 0);
        chk("done_hold", int'(done), 1);
        chk("num_samples", int'(num_samples), n >= 256 ? 256 : n);
        chk("oldest_addr", int'(oldest_addr), n >= 256 ? n % 256 : 0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        trigger_en = 1'b0;
        trigger_din = 1'b0;
        trig_mask = 1'b0;
        trig_value = 1'b0;
        post_cnt = 8'd0;
        trace_din = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_triggered", int'(triggered), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_trig_addr", int'(trig_addr), 0);
        chk("rst_oldest", int'(oldest_addr), 0);
        chk("rst_num", int'(num_samples), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            post_cnt = 8'd0;
            trigger_en = 1'b0;
            arm = 1'b1;
            tick();
            arm = 1'b0;
            trigger_en  = tbl[i].en;
            trigger_din = tbl[i].din;
            trig_mask   = tbl[i].mask;
            trig_value  = tbl[i].value;
            tick();
            chk($sformatf("vec%0d_triggered", i), int'(triggered), int'(tbl[i].exp));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(!tbl[i].exp));
            trigger_en = 1'b0;
            tick();
            chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].exp));
        end

        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_wr_en", int'(wr_en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_wr_addr", int'(wr_addr), 0);
        chk("async_num", int'(num_samples), 0);
        @(negedge clk);
        reset_n = 1'b1;
        got_a.delete();
        trigger_en = 1'b1;
        trig_mask = 1'b0;
        repeat (5) tick();
        chk("post_rst_writes", got_a.size(), 0);
        chk("post_rst_busy", int'(busy), 0);

        run(3, 0, 1'b0);
        run(10, 300, 1'b0);
        run(255, 0, 1'b0);
        run(5, 50, 1'b0);
        run(200, 270, 1'b1);
        for (int r = 0; r < 6; r++)
            run(int'($urandom_range(0, 30)), int'($urandom_range(0, 20)), 1'b1);

        post_cnt = 8'd20;
        trigger_en = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (5) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_ignored_addr", int'(wr_addr), 5);
        chk("rearm_busy", int'(busy), 1);
        trigger_en = 1'b1;
        trig_mask = 1'b0;
        tick();
        trigger_en = 1'b0;
        chk("post_triggered", int'(triggered), 1);
        chk("post_busy", int'(busy), 1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_triggered", int'(triggered), 0);
        chk("abort_done", int'(done), 0);
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        chk("armabort_busy", int'(busy), 0);
        tick();
        chk("armabort_wr_en", int'(wr_en), 0);
        chk("armabort_busy2", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
